// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ALU and LSU writeback requests onto a
// single registered register-file write port, and runs a clear sequence
// that zeroes registers 1..top.
//
// Ports:
//   Clock, Reset                          clock, async active-high reset
//   AluValid/AluAddress/AluData, AluReady ALU writeback request/accept
//   LsuValid/LsuAddress/LsuData, LsuReady LSU writeback request/accept
//   ClearStart                            one-cycle request to zero the file
//   ClearBusy                             clear sequence in progress
//   RegWrite/WriteAddress/WriteData       registered write port
module regfile_wb_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  AluValid,
    input  logic [ADDR_WIDTH-1:0] AluAddress,
    input  logic [DATA_WIDTH-1:0] AluData,
    output logic                  AluReady,
    input  logic                  LsuValid,
    input  logic [ADDR_WIDTH-1:0] LsuAddress,
    input  logic [DATA_WIDTH-1:0] LsuData,
    output logic                  LsuReady,
    input  logic                  ClearStart,
    output logic                  ClearBusy,
    output logic                  RegWrite,
    output logic [ADDR_WIDTH-1:0] WriteAddress,
    output logic [DATA_WIDTH-1:0] WriteData
);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR  = '1;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;
    localparam logic                  SRC_ALU   = 1'b0;
    localparam logic                  SRC_LSU   = 1'b1;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clear_cnt_q, clear_cnt_d;
    logic                    last_grant_q, last_grant_d;
    logic                    grant_alu, grant_lsu;
    logic                    reg_write_d;
    logic [ADDR_WIDTH-1:0]   write_address_d;
    logic [DATA_WIDTH-1:0]   write_data_d;
    logic                    clear_busy_d;

    // State, counter, pointer and write-port registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_ARB;
            clear_cnt_q  <= '0;
            last_grant_q <= SRC_LSU;
            RegWrite     <= 1'b0;
            WriteAddress <= '0;
            WriteData    <= '0;
            ClearBusy    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_cnt_q  <= clear_cnt_d;
            last_grant_q <= last_grant_d;
            RegWrite     <= reg_write_d;
            WriteAddress <= write_address_d;
            WriteData    <= write_data_d;
            ClearBusy    <= clear_busy_d;
        end
    end

    // Arbitration, clear sequencing and next write-port values
    always_comb begin
        state_d         = state_q;
        clear_cnt_d     = clear_cnt_q;
        last_grant_d    = last_grant_q;
        grant_alu       = 1'b0;
        grant_lsu       = 1'b0;
        reg_write_d     = 1'b0;
        write_address_d = WriteAddress;
        write_data_d    = WriteData;
        clear_busy_d    = 1'b0;

        case (state_q)
            ST_ARB: begin
                if (ClearStart) begin
                    state_d      = ST_CLEAR;
                    clear_cnt_d  = ADDR_WIDTH'(1);
                    clear_busy_d = 1'b1;
                end else begin
                    // On a tie the source that did not win last time wins
                    if (AluValid && (!LsuValid || (last_grant_q == SRC_LSU))) begin
                        grant_alu = 1'b1;
                    end else if (LsuValid) begin
                        grant_lsu = 1'b1;
                    end

                    // Register 0 is hardwired: accept the request, drop the write
                    if (grant_alu) begin
                        last_grant_d = SRC_ALU;
                        if (AluAddress != ZERO_ADDR) begin
                            reg_write_d     = 1'b1;
                            write_address_d = AluAddress;
                            write_data_d    = AluData;
                        end
                    end else if (grant_lsu) begin
                        last_grant_d = SRC_LSU;
                        if (LsuAddress != ZERO_ADDR) begin
                            reg_write_d     = 1'b1;
                            write_address_d = LsuAddress;
                            write_data_d    = LsuData;
                        end
                    end
                end
            end

            ST_CLEAR: begin
                reg_write_d     = 1'b1;
                write_address_d = clear_cnt_q;
                write_data_d    = '0;
                // Leave on the edge that writes the top register; no wrap to 0
                if (clear_cnt_q == TOP_ADDR) begin
                    state_d     = ST_ARB;
                    clear_cnt_d = '0;
                end else begin
                    clear_cnt_d  = clear_cnt_q + ADDR_WIDTH'(1);
                    clear_busy_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    assign AluReady = grant_alu;
    assign LsuReady = grant_lsu;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a vector table for arbitration and
// write latency, plus hand sequences for the clear and reset-abort cases.
module tb_regfile_wb_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          Clock;
    logic          Reset;
    logic          AluValid;
    logic [AW-1:0] AluAddress;
    logic [DW-1:0] AluData;
    logic          AluReady;
    logic          LsuValid;
    logic [AW-1:0] LsuAddress;
    logic [DW-1:0] LsuData;
    logic          LsuReady;
    logic          ClearStart;
    logic          ClearBusy;
    logic          RegWrite;
    logic [AW-1:0] WriteAddress;
    logic [DW-1:0] WriteData;

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .AluValid     (AluValid),
        .AluAddress   (AluAddress),
        .AluData      (AluData),
        .AluReady     (AluReady),
        .LsuValid     (LsuValid),
        .LsuAddress   (LsuAddress),
        .LsuData      (LsuData),
        .LsuReady     (LsuReady),
        .ClearStart   (ClearStart),
        .ClearBusy    (ClearBusy),
        .RegWrite     (RegWrite),
        .WriteAddress (WriteAddress),
        .WriteData    (WriteData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          lv;
        logic [AW-1:0] la;
        logic [DW-1:0] ld;
        logic          exp_ar;
        logic          exp_lr;
        logic          exp_rw;
        logic [AW-1:0] exp_wa;
        logic [DW-1:0] exp_wd;
        logic          chk_bus;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    function automatic vec_t mk(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                                input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                                input logic ar, input logic lr, input logic rw,
                                input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic cb);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.lv = lv; v.la = la; v.ld = ld;
        v.exp_ar = ar; v.exp_lr = lr; v.exp_rw = rw;
        v.exp_wa = wa; v.exp_wd = wd; v.chk_bus = cb;
        return v;
    endfunction

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs;
        AluValid = 1'b0; AluAddress = '0; AluData = '0;
        LsuValid = 1'b0; LsuAddress = '0; LsuData = '0;
        ClearStart = 1'b0;
    endtask

    int busy_cycles;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Arbitration / latency vectors; readies checked before the edge,
        // write port checked after it
        vecs[0]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 32'h0,        1);
        vecs[1]  = mk(1, 1, 32'h11111111, 1, 2, 32'h22222222, 1, 0, 1, 1, 32'h11111111, 1);
        vecs[2]  = mk(1, 1, 32'h11111111, 1, 2, 32'h22222222, 0, 1, 1, 2, 32'h22222222, 1);
        vecs[3]  = mk(1, 1, 32'h11111111, 1, 2, 32'h22222222, 1, 0, 1, 1, 32'h11111111, 1);
        vecs[4]  = mk(1, 1, 32'h11111111, 1, 2, 32'h22222222, 0, 1, 1, 2, 32'h22222222, 1);
        vecs[5]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 2, 32'h22222222, 1);
        vecs[6]  = mk(1, 5, 32'hAAAABBBB, 0, 0, 0,            1, 0, 1, 5, 32'hAAAABBBB, 1);
        vecs[7]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 5, 32'hAAAABBBB, 1);
        vecs[8]  = mk(0, 0, 0,            1, 0, 32'hDEADBEEF, 0, 1, 0, 0, 32'h0,        0);
        vecs[9]  = mk(0, 0, 0,            1, 3, 32'h33333333, 0, 1, 1, 3, 32'h33333333, 1);
        vecs[10] = mk(1, 4, 32'h44444444, 1, 6, 32'h66666666, 1, 0, 1, 4, 32'h44444444, 1);
        vecs[11] = mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 4, 32'h44444444, 1);

        idle_inputs();
        Reset = 1'b1;
        #1;
        check("reset_regwrite", DW'(RegWrite), 0);
        check("reset_waddr", DW'(WriteAddress), 0);
        check("reset_wdata", WriteData, 0);
        check("reset_busy", DW'(ClearBusy), 0);
        tick(); tick();
        Reset = 1'b0;
        check("post_reset_regwrite", DW'(RegWrite), 0);

        for (int i = 0; i < NVEC; i++) begin
            AluValid = vecs[i].av; AluAddress = vecs[i].aa; AluData = vecs[i].ad;
            LsuValid = vecs[i].lv; LsuAddress = vecs[i].la; LsuData = vecs[i].ld;
            #1;
            check($sformatf("v%0d_alu_ready", i), DW'(AluReady), DW'(vecs[i].exp_ar));
            check($sformatf("v%0d_lsu_ready", i), DW'(LsuReady), DW'(vecs[i].exp_lr));
            tick();
            check($sformatf("v%0d_regwrite", i), DW'(RegWrite), DW'(vecs[i].exp_rw));
            if (vecs[i].chk_bus) begin
                check($sformatf("v%0d_waddr", i), DW'(WriteAddress), DW'(vecs[i].exp_wa));
                check($sformatf("v%0d_wdata", i), WriteData, vecs[i].exp_wd);
            end
            check($sformatf("v%0d_busy", i), DW'(ClearBusy), 0);
        end
        idle_inputs();

        // Clear with a concurrent ALU request that must wait it out
        ClearStart = 1'b1;
        AluValid = 1'b1; AluAddress = 5'd7; AluData = 32'h77777777;
        #1;
        check("clr_start_alu_ready", DW'(AluReady), 0);
        check("clr_start_lsu_ready", DW'(LsuReady), 0);
        tick();
        ClearStart = 1'b0;
        check("clr_e0_busy", DW'(ClearBusy), 1);
        check("clr_e0_regwrite", DW'(RegWrite), 0);
        busy_cycles = 1;
        for (int k = 1; k <= 31; k++) begin
            ClearStart = (k == 10);
            #1;
            check($sformatf("clr_k%0d_alu_ready", k), DW'(AluReady), 0);
            tick();
            ClearStart = 1'b0;
            check($sformatf("clr_k%0d_regwrite", k), DW'(RegWrite), 1);
            check($sformatf("clr_k%0d_waddr", k), DW'(WriteAddress), DW'(k));
            check($sformatf("clr_k%0d_wdata", k), WriteData, 0);
            check($sformatf("clr_k%0d_busy", k), DW'(ClearBusy), DW'(k < 31));
            if (ClearBusy) busy_cycles++;
        end
        check("clr_busy_cycles", DW'(busy_cycles), 31);
        #1;
        check("clr_done_alu_ready", DW'(AluReady), 1);
        tick();
        AluValid = 1'b0;
        check("clr_after_regwrite", DW'(RegWrite), 1);
        check("clr_after_waddr", DW'(WriteAddress), 7);
        check("clr_after_wdata", WriteData, 32'h77777777);
        tick();
        check("clr_after_idle_regwrite", DW'(RegWrite), 0);

        // Reset in the middle of a clear aborts it
        idle_inputs();
        ClearStart = 1'b1;
        tick();
        ClearStart = 1'b0;
        repeat (10) tick();
        check("abort_pre_waddr", DW'(WriteAddress), 10);
        Reset = 1'b1;
        #1;
        check("abort_regwrite", DW'(RegWrite), 0);
        check("abort_waddr", DW'(WriteAddress), 0);
        check("abort_wdata", WriteData, 0);
        check("abort_busy", DW'(ClearBusy), 0);
        tick();
        Reset = 1'b0;
        for (int c = 0; c < 25; c++) begin
            tick();
            check($sformatf("abort_c%0d_regwrite", c), DW'(RegWrite), 0);
        end
        AluValid = 1'b1; AluAddress = 5'd9; AluData = 32'h99999999;
        LsuValid = 1'b1; LsuAddress = 5'd3; LsuData = 32'h33333333;
        #1;
        check("abort_tie_alu_ready", DW'(AluReady), 1);
        check("abort_tie_lsu_ready", DW'(LsuReady), 0);
        tick();
        idle_inputs();
        check("abort_tie_regwrite", DW'(RegWrite), 1);
        check("abort_tie_waddr", DW'(WriteAddress), 9);
        check("abort_tie_wdata", WriteData, 32'h99999999);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of write data.
REQ-002 Parameter ADDR_WIDTH, default 5, width of register address; the top register is index 2^ADDR_WIDTH-1.
REQ-003 The clock is a single clock, Clock; reset is asynchronous and active-high, Reset.
REQ-004 Clock  input  1  system clock; all state updates on posedge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 AluValid / AluAddress / AluData  input  1 / ADDR_WIDTH / DATA_WIDTH  ALU writeback request.
REQ-007 AluReady  output  1  ALU request accepted this cycle (combinational).
REQ-008 LsuValid / LsuAddress / LsuData  input  1 / ADDR_WIDTH / DATA_WIDTH  load/store-unit writeback request.
REQ-009 LsuReady  output  1  LSU request accepted this cycle (combinational).
REQ-010 ClearStart  input  1  single-cycle request to zero the register file.
REQ-011 ClearBusy  output  1  clear sequence in progress (registered).
REQ-012 RegWrite / WriteAddress / WriteData  output  1 / ADDR_WIDTH / DATA_WIDTH  registered write port driving the register file.

Function
REQ-013 The FSM SHALL have two states, ARB and CLEAR, plus a clear counter of ADDR_WIDTH bits and a 1-bit LastGrant pointer.
REQ-014 Transfer rule: a request transfers at posedge when its Valid and Ready are both 1; the requester holds Valid/Address/Data stable until then.
REQ-015 Ready SHALL be 0 for both sources in CLEAR, and in ARB whenever ClearStart=1.
REQ-016 In ARB with ClearStart=0: one source valid means it is granted; both valid means the source not equal to LastGrant is granted; no source valid means no grant.
REQ-017 LastGrant SHALL update to the granted source on every transfer.
REQ-018 Write latency: a transfer at edge N SHALL present RegWrite=1 with that Address/Data during the cycle after edge N.
REQ-019 A cycle with no transfer and no clear write SHALL load RegWrite=0; WriteAddress and WriteData hold their previous values.
REQ-020 Address 0 requests SHALL be accepted normally (Ready=1, pointer updated) but SHALL load RegWrite=0.
REQ-021 Sustained contention: with both sources continuously valid, grants SHALL alternate and RegWrite=1 every cycle; no source waits more than 1 cycle.
REQ-022 ARB to CLEAR on ClearStart=1 at posedge; the counter loads 1; ClearBusy=1 from that edge.
REQ-023 In CLEAR, each posedge SHALL load RegWrite=1, WriteAddress=counter, WriteData=0, and increment the counter.
REQ-024 The edge that loads the top address SHALL return the FSM to ARB; ClearBusy is high for exactly 2^ADDR_WIDTH-1 cycles.
REQ-025 RegWrite pulses for the clear SHALL run consecutively, lagging ClearBusy by one cycle.
REQ-026 ClearStart during CLEAR SHALL be ignored.
REQ-027 Requests SHALL be acceptable in the first ARB cycle after CLEAR, giving zero-bubble write output.
REQ-028 The counter SHALL never wrap; address 0 is never issued by the clear.

Reset
REQ-029 Reset=1 SHALL immediately force RegWrite=0, WriteAddress=0, WriteData=0, ClearBusy=0, state ARB, counter 0, and LastGrant=LSU (so the ALU wins the first tie).
REQ-030 Reset asserted mid-clear SHALL abort the sequence with no further writes; Ready outputs follow REQ-016 once Reset is released.

Verification
REQ-031 Reset then idle -> all outputs 0; AluReady follows AluValid with no clear and no LSU request.
REQ-032 ALU addr 5, data 0xAAAABBBB for one cycle -> AluReady=1 that cycle; next cycle RegWrite=1, WriteAddress=5, WriteData=0xAAAABBBB; following cycle RegWrite=0.
REQ-033 ALU (addr 1, 0x11111111) and LSU (addr 2, 0x22222222) both held valid -> grants ALU, LSU, ALU, ...; RegWrite=1 every cycle with alternating address/data.
REQ-034 LSU addr 0, data 0xDEADBEEF -> LsuReady=1; RegWrite stays 0.
REQ-035 ClearStart together with AluValid (addr 7) -> AluReady=0; ClearBusy high 31 cycles; RegWrite writes addresses 1..31 with data 0; the ALU request is accepted in the first cycle ClearBusy=0 and its write follows address 31 with no gap.
REQ-036 Reset asserted while WriteAddress=10 during clear -> outputs 0 immediately, ClearBusy=0, no writes to addresses 11..31.
